// File: rtl/catcore_pkg.sv
// Shared CatCORE definitions: opcode field values and the fetch FSM states.
package catcore_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_IN   = 6'b000111;
    localparam logic [5:0] OP_BEQ  = 6'b010110;
    localparam logic [5:0] OP_BNQ  = 6'b010111;
    localparam logic [5:0] OP_HALT = 6'b111110;
    localparam logic [5:0] OP_JUMP = 6'b111111;

    typedef enum logic [1:0] {
        EXEC,
        ESPERA_IN,
        COMMIT_IN,
        PARADO
    } estado_t;

    function automatic logic [5:0] opcode_de(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/unidade_busca_if.sv
// Fetch-stage bus: instruction memory address/data, datapath hand-off and status.
interface unidade_busca_if;

    logic [31:0] instrucao;
    logic        desvio_tomado;
    logic        confirmacao;
    logic [31:0] endereco;
    logic        instrucao_valida;
    logic        esperando_in;
    logic        parado;
    logic        erro_endereco;

    modport master (
        input  instrucao, desvio_tomado, confirmacao,
        output endereco, instrucao_valida, esperando_in, parado, erro_endereco
    );

    modport slave (
        output instrucao, desvio_tomado, confirmacao,
        input  endereco, instrucao_valida, esperando_in, parado, erro_endereco
    );

endinterface

// File: rtl/unidade_busca_sincroniza_borda.sv
// Synchroniser chain for an asynchronous push button plus rising-edge detect.
module sincroniza_borda #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic entrada,
    output logic borda
);

    logic [SYNC_STAGES-1:0] cadeia;
    logic                   anterior;

    // Shift the raw input through the chain; remember the last synchronised value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cadeia   <= '0;
            anterior <= 1'b0;
        end else begin
            cadeia[0] <= entrada;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                cadeia[i] <= cadeia[i-1];
            end
            anterior <= cadeia[SYNC_STAGES-1];
        end
    end

    // One-cycle pulse on a 0->1 transition of the synchronised signal.
    always_comb begin
        borda = cadeia[SYNC_STAGES-1] & ~anterior;
    end

endmodule

// File: rtl/unidade_busca.sv
// CatCORE fetch/sequencing stage: owns the PC, picks the next PC from the
// fetched word, stalls on IN and HALT, and issues the per-cycle commit strobe.
module unidade_busca
    import catcore_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 71,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    unidade_busca_if.master bus
);

    estado_t     estado;
    logic [31:0] pc;
    logic [31:0] pc_prox;
    logic        pode_commit;
    logic        esperando_q;
    logic        parado_q;
    logic        erro_q;
    logic [5:0]  opcode;
    logic        fora_faixa;
    logic        squash_exec;
    logic        confirma_borda;

    sincroniza_borda #(.SYNC_STAGES(SYNC_STAGES)) u_sincroniza (
        .clock   (clock),
        .reset_n (reset_n),
        .entrada (bus.confirmacao),
        .borda   (confirma_borda)
    );

    // Decode the fetched word and flag a PC outside the instruction memory.
    always_comb begin
        opcode      = opcode_de(bus.instrucao);
        fora_faixa  = (estado != PARADO) && (pc > 32'(MEM_DEPTH - 1));
        squash_exec = (estado == EXEC) && ((opcode == OP_IN) || (opcode == OP_HALT));
    end

    // Next-PC mux for an instruction executing in EXEC.
    always_comb begin
        pc_prox = pc + 32'd1;
        case (opcode)
            OP_JUMP: pc_prox = {6'b0, bus.instrucao[25:0]};
            OP_BEQ, OP_BNQ: begin
                if (bus.desvio_tomado) begin
                    pc_prox = {16'b0, bus.instrucao[15:0]};
                end
            end
            default: pc_prox = pc + 32'd1;
        endcase
    end

    // Commit strobe: registered eligibility, squashed by IN/HALT or a bad PC.
    always_comb begin
        bus.instrucao_valida = pode_commit & ~fora_faixa & ~squash_exec;
        bus.endereco         = pc;
        bus.esperando_in     = esperando_q;
        bus.parado           = parado_q;
        bus.erro_endereco    = erro_q;
    end

    // Sequencing FSM. pode_commit is low only in the post-reset bubble and in
    // the stall/halt states, so EXEC with pode_commit low marks that bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= EXEC;
            pc          <= '0;
            pode_commit <= 1'b0;
            esperando_q <= 1'b0;
            parado_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else if (fora_faixa) begin
            estado      <= PARADO;
            pode_commit <= 1'b0;
            esperando_q <= 1'b0;
            parado_q    <= 1'b1;
            erro_q      <= 1'b1;
        end else begin
            case (estado)
                EXEC: begin
                    if (!pode_commit) begin
                        pode_commit <= 1'b1;
                    end else if (opcode == OP_IN) begin
                        estado      <= ESPERA_IN;
                        pode_commit <= 1'b0;
                        esperando_q <= 1'b1;
                    end else if (opcode == OP_HALT) begin
                        estado      <= PARADO;
                        pode_commit <= 1'b0;
                        parado_q    <= 1'b1;
                    end else begin
                        pc <= pc_prox;
                    end
                end
                ESPERA_IN: begin
                    if (confirma_borda) begin
                        estado      <= COMMIT_IN;
                        pode_commit <= 1'b1;
                        esperando_q <= 1'b0;
                    end
                end
                COMMIT_IN: begin
                    estado <= EXEC;
                    pc     <= pc + 32'd1;
                end
                PARADO: begin
                    estado <= PARADO;
                end
                default: begin
                    estado <= PARADO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomised programs.
module tb_unidade_busca;
    import catcore_pkg::*;

    localparam int unsigned MEM_DEPTH = 71;
    localparam int unsigned SYNC      = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    unidade_busca_if bus();

    unidade_busca #(.MEM_DEPTH(MEM_DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:127];
    int errors = 0;
    int checks = 0;

    // Instruction memory: combinational read at the DUT's address.
    always_comb begin
        bus.instrucao = (bus.endereco < 32'd128) ? mem[bus.endereco[6:0]] : 32'h0;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model state.
    logic [31:0] m_pc;
    bit m_first, m_wait, m_commit, m_halt, m_err;
    bit samp [0:SYNC];

    // Compare every cycle at the falling edge, then advance the model to the next rising edge.
    always @(negedge clock) begin : modelo
        logic [31:0] w;
        logic [5:0]  op;
        logic [31:0] n_pc;
        bit n_first, n_wait, n_commit, n_halt, n_err, exp_v;
        if (!reset_n) begin
            m_pc = 0; m_first = 1; m_wait = 0; m_commit = 0; m_halt = 0; m_err = 0;
            for (int i = 0; i <= SYNC; i++) samp[i] = 0;
            chk("rst_endereco", bus.endereco, 32'd0);
            chk("rst_valida", 32'(bus.instrucao_valida), 32'd0);
            chk("rst_parado", 32'(bus.parado), 32'd0);
            chk("rst_erro", 32'(bus.erro_endereco), 32'd0);
            chk("rst_esperando", 32'(bus.esperando_in), 32'd0);
        end else begin
            w  = (m_pc < 32'd128) ? mem[m_pc[6:0]] : 32'h0;
            op = w[31:26];
            n_pc = m_pc; n_first = 0; n_wait = m_wait; n_commit = m_commit;
            n_halt = m_halt; n_err = m_err; exp_v = 0;
            if (m_halt) begin
                exp_v = 0;
            end else if (m_pc > 32'(MEM_DEPTH - 1)) begin
                n_halt = 1; n_err = 1; n_wait = 0; n_commit = 0;
            end else if (m_first) begin
                exp_v = 0;
            end else if (m_wait) begin
                if (samp[SYNC-1] && !samp[SYNC]) begin
                    n_wait = 0; n_commit = 1;
                end
            end else if (m_commit) begin
                exp_v = 1; n_pc = m_pc + 1; n_commit = 0;
            end else if (op == OP_IN) begin
                n_wait = 1;
            end else if (op == OP_HALT) begin
                n_halt = 1;
            end else begin
                exp_v = 1;
                if (op == OP_JUMP) n_pc = w & 32'h03FF_FFFF;
                else if ((op == OP_BEQ || op == OP_BNQ) && bus.desvio_tomado) n_pc = w & 32'h0000_FFFF;
                else n_pc = m_pc + 1;
            end
            chk("mdl_endereco", bus.endereco, m_pc);
            chk("mdl_valida", 32'(bus.instrucao_valida), 32'(exp_v));
            chk("mdl_esperando", 32'(bus.esperando_in), 32'(m_wait));
            chk("mdl_parado", 32'(bus.parado), 32'(m_halt));
            chk("mdl_erro", 32'(bus.erro_endereco), 32'(m_err));
            m_pc = n_pc; m_first = n_first; m_wait = n_wait; m_commit = n_commit;
            m_halt = n_halt; m_err = n_err;
            for (int i = SYNC; i > 0; i--) samp[i] = samp[i-1];
            samp[0] = bus.confirmacao;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        bus.desvio_tomado = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic wait_pc(input logic [31:0] t, input int budget);
        int n = 0;
        while (bus.endereco !== t && n < budget) begin
            tick();
            n++;
        end
        chk("reach_pc", bus.endereco, t);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : estimulo
        logic [31:0] w;
        bus.desvio_tomado = 1'b0;
        bus.confirmacao   = 1'b0;

        // Sequential run, JUMP, BNQ taken/not taken, HALT.
        clear_mem();
        mem[1] = 32'h0400_0005;
        mem[2] = 32'h0400_0007;
        mem[5] = 32'hFC00_0008;
        mem[6] = 32'h0400_0001;
        mem[12] = 32'h5C05_0006;
        mem[13] = 32'hF800_0000;
        apply_reset();
        chk("t1_pc_bubble", bus.endereco, 32'd0);
        chk("t1_valida_bubble", 32'(bus.instrucao_valida), 32'd0);
        tick();
        chk("t1_pc0", bus.endereco, 32'd0);
        chk("t1_valida0", 32'(bus.instrucao_valida), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t1_pc_seq", bus.endereco, 32'(i));
            chk("t1_valida_seq", 32'(bus.instrucao_valida), 32'd1);
        end
        tick();
        chk("t2_jump", bus.endereco, 32'd8);
        wait_pc(32'd12, 10);
        bus.desvio_tomado = 1'b1;
        tick();
        chk("t3_bnq_taken", bus.endereco, 32'd6);
        bus.desvio_tomado = 1'b0;
        wait_pc(32'd12, 10);
        tick();
        chk("t3_bnq_not_taken", bus.endereco, 32'd13);
        chk("t5_halt_squash", 32'(bus.instrucao_valida), 32'd0);
        tick();
        chk("t5_parado", 32'(bus.parado), 32'd1);
        repeat (20) begin
            tick();
            chk("t5_pc_frozen", bus.endereco, 32'd13);
        end

        // IN stall with button held at entry, fresh press, then HALT and reset.
        clear_mem();
        mem[1] = 32'h1C00_0000;
        mem[3] = 32'hF800_0000;
        bus.confirmacao = 1'b1;
        apply_reset();
        tick();
        tick();
        chk("t4_in_pc", bus.endereco, 32'd1);
        chk("t4_in_squash", 32'(bus.instrucao_valida), 32'd0);
        tick();
        chk("t4_esperando", 32'(bus.esperando_in), 32'd1);
        repeat (5) tick();
        chk("t4_held_still_stalled", 32'(bus.esperando_in), 32'd1);
        chk("t4_held_pc", bus.endereco, 32'd1);
        bus.confirmacao = 1'b0;
        repeat (4) tick();
        chk("t4_released_stalled", 32'(bus.esperando_in), 32'd1);
        bus.confirmacao = 1'b1;
        tick();
        chk("t4_sync1", 32'(bus.instrucao_valida), 32'd0);
        tick();
        chk("t4_sync2", 32'(bus.instrucao_valida), 32'd0);
        tick();
        chk("t4_commit_pulse", 32'(bus.instrucao_valida), 32'd1);
        chk("t4_commit_pc", bus.endereco, 32'd1);
        tick();
        chk("t4_after_commit_pc", bus.endereco, 32'd2);
        tick();
        chk("t5_halt_pc", bus.endereco, 32'd3);
        chk("t5_halt_valida", 32'(bus.instrucao_valida), 32'd0);
        tick();
        chk("t5_parado2", 32'(bus.parado), 32'd1);
        repeat (100) begin
            tick();
            chk("t5_frozen100", bus.endereco, 32'd3);
        end
        reset_n = 1'b0;
        #1;
        chk("t5_reset_pc", bus.endereco, 32'd0);
        chk("t5_reset_parado", 32'(bus.parado), 32'd0);

        // Range error via JUMP to 0x50, async clear, then reset mid-stall.
        clear_mem();
        mem[0] = 32'hFC00_0050;
        bus.confirmacao = 1'b0;
        apply_reset();
        tick();
        chk("t6_pc0", bus.endereco, 32'd0);
        tick();
        chk("t6_pc_bad", bus.endereco, 32'h50);
        chk("t6_valida_bad", 32'(bus.instrucao_valida), 32'd0);
        tick();
        chk("t6_erro", 32'(bus.erro_endereco), 32'd1);
        chk("t6_parado", 32'(bus.parado), 32'd1);
        chk("t6_valida_after", 32'(bus.instrucao_valida), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("t6_reset_erro", 32'(bus.erro_endereco), 32'd0);
        chk("t6_reset_parado", 32'(bus.parado), 32'd0);
        mem[0] = 32'h1C00_0000;
        apply_reset();
        tick();
        tick();
        chk("t6_stall", 32'(bus.esperando_in), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_midstall_esperando", 32'(bus.esperando_in), 32'd0);
        chk("t6_midstall_pc", bus.endereco, 32'd0);
        chk("t6_midstall_valida", 32'(bus.instrucao_valida), 32'd0);

        // Randomised programs checked by the model every cycle.
        for (int ep = 0; ep < 10; ep++) begin
            for (int a = 0; a < 128; a++) begin
                int r;
                r = $urandom_range(0, 99);
                w = $urandom;
                if (a < MEM_DEPTH) begin
                    if (r < 10)      w = {OP_JUMP, 26'($urandom_range(0, 74))};
                    else if (r < 28) w = {($urandom_range(0, 1) == 1) ? OP_BEQ : OP_BNQ,
                                          10'($urandom), 16'($urandom_range(0, 74))};
                    else if (r < 34) w = {OP_IN, 26'($urandom)};
                    else if (r < 36) w = {OP_HALT, 26'($urandom)};
                end
                mem[a] = w;
            end
            bus.confirmacao = 1'b0;
            apply_reset();
            repeat (300) begin
                bus.desvio_tomado = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) bus.confirmacao = ~bus.confirmacao;
                tick();
            end
        end

        @(posedge clock);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
